ctx_loader: RTL and testbench

CTX_LOADER -- requirements
Module: ctx_loader

---
 rtl/ctx_loader.sv | 148 ++++++++++++++
 tb/tb_ctx_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ctx_loader.sv
// Stream-driven loader for context/LDM memories with start/complete handshake.
// Also measures the cycle count of each array-core run.
module ctx_loader #(
  parameter int DW = 32,
  parameter int AW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] s_data_in,
  input  logic          s_valid_in,
  output logic          s_ready_out,
  output logic [AW-1:0] mem_addr_out,
  output logic [DW-1:0] mem_din_out,
  output logic [3:0]    mem_ena_out,
  output logic          mem_wea_out,
  output logic          start_out,
  input  logic          complete_in,
  output logic          busy_out,
  output logic          done_out,
  output logic          err_out,
  output logic [31:0]   cycles_out
);

  typedef enum logic [2:0] {
    IDLE, LOAD, DROP, START, WAIT
  } state_t;

  state_t state, next;

  logic [2:0]    op;
  logic [12:0]   cnt;
  logic [AW-1:0] base;
  logic          accept;
  logic          is_wr;
  logic          is_start;
  logic          illegal;
  logic          last;
  logic          rise;

  logic [AW-1:0] addr;
  logic [12:0]   remaining;
  logic [1:0]    sel;
  logic [31:0]   counter;
  logic          complete_prev;

  assign op       = s_data_in[31:29];
  assign cnt      = s_data_in[28:16];
  assign base     = s_data_in[AW-1:0];
  assign accept   = s_valid_in & s_ready_out;
  assign is_wr    = ~op[2];
  assign is_start = (op == 3'b100);
  assign illegal  = op[2] & (op[1:0] != 2'b00);
  assign last     = (remaining == 13'd1);
  assign rise     = complete_in & ~complete_prev;

  assign mem_wea_out = |mem_ena_out;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next        = state;
    s_ready_out = 1'b0;
    busy_out    = 1'b1;
    start_out   = 1'b0;
    unique case (state)
      IDLE: begin
        s_ready_out = 1'b1;
        busy_out    = 1'b0;
        if (accept) begin
          unique case (1'b1)
            is_wr:    if (cnt != 13'd0) next = LOAD;
            is_start: next = START;
            default:  if (cnt != 13'd0) next = DROP;
          endcase
        end
      end
      LOAD, DROP: begin
        s_ready_out = 1'b1;
        if (accept && last) next = IDLE;
      end
      START: begin
        start_out = 1'b1;
        next      = WAIT;
      end
      WAIT: begin
        if (rise) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr          <= '0;
      remaining     <= '0;
      sel           <= '0;
      counter       <= '0;
      complete_prev <= 1'b0;
      mem_addr_out  <= '0;
      mem_din_out   <= '0;
      mem_ena_out   <= '0;
      done_out      <= 1'b0;
      err_out       <= 1'b0;
      cycles_out    <= '0;
    end else begin
      complete_prev <= complete_in;
      mem_ena_out   <= '0;
      done_out      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && !is_start) begin
            addr      <= base;
            remaining <= cnt;
            sel       <= op[1:0];
            if (illegal) err_out <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            mem_ena_out  <= 4'b0001 << sel;
            mem_addr_out <= addr;
            mem_din_out  <= s_data_in;
            addr         <= addr + AW'(1);
            remaining    <= remaining - 13'd1;
          end
        end
        DROP: begin
          if (accept) remaining <= remaining - 13'd1;
        end
        START: counter <= 32'd1;
        WAIT: begin
          // Only a fresh edge counts; a level left high by the last run is ignored.
          if (rise) begin
            cycles_out <= counter;
            done_out   <= 1'b1;
          end else if (counter != 32'hFFFF_FFFF) begin
            counter <= counter + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctx_loader.sv
// Directed bench for ctx_loader: loads, wrap, illegal ops, start/complete, reset abort.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ctx_loader;

  logic        CLK;
  logic        RST;
  logic [31:0] s_data_in;
  logic        s_valid_in;
  logic        s_ready_out;
  logic [15:0] mem_addr_out;
  logic [31:0] mem_din_out;
  logic [3:0]  mem_ena_out;
  logic        mem_wea_out;
  logic        start_out;
  logic        complete_in;
  logic        busy_out;
  logic        done_out;
  logic        err_out;
  logic [31:0] cycles_out;

  int n_cmp = 0;
  int n_bad = 0;

  ctx_loader #(.DW(32), .AW(16)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .s_data_in    (s_data_in),
    .s_valid_in   (s_valid_in),
    .s_ready_out  (s_ready_out),
    .mem_addr_out (mem_addr_out),
    .mem_din_out  (mem_din_out),
    .mem_ena_out  (mem_ena_out),
    .mem_wea_out  (mem_wea_out),
    .start_out    (start_out),
    .complete_in  (complete_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .err_out      (err_out),
    .cycles_out   (cycles_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    s_valid_in = 1'b1;
    s_data_in  = w;
    tick();
  endtask

  task automatic idle();
    s_valid_in = 1'b0;
    tick();
  endtask

  task automatic wr(input string tag, input logic [3:0] ena,
                    input logic [15:0] a, input logic [31:0] d);
    check({tag, "_ena"}, 64'(mem_ena_out), 64'(ena));
    check({tag, "_wea"}, 64'(mem_wea_out), 64'(1'b1));
    check({tag, "_addr"}, 64'(mem_addr_out), 64'(a));
    check({tag, "_din"}, 64'(mem_din_out), 64'(d));
  endtask

  initial begin
    RST         = 1'b1;
    s_valid_in  = 1'b0;
    s_data_in   = '0;
    complete_in = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    tick();
    check("rst_ready", 64'(s_ready_out), 64'd1);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_ena", 64'(mem_ena_out), 64'd0);
    check("rst_wea", 64'(mem_wea_out), 64'd0);
    check("rst_addr", 64'(mem_addr_out), 64'd0);
    check("rst_din", 64'(mem_din_out), 64'd0);
    check("rst_start", 64'(start_out), 64'd0);
    check("rst_done", 64'(done_out), 64'd0);
    check("rst_err", 64'(err_out), 64'd0);
    check("rst_cycles", 64'(cycles_out), 64'd0);

    // RC load of three words, back to back
    send(32'h0003_0010);
    check("rc_hdr_ena", 64'(mem_ena_out), 64'd0);
    check("rc_hdr_busy", 64'(busy_out), 64'd1);
    send(32'hAAAA_0001);
    wr("rc_w0", 4'b0001, 16'h0010, 32'hAAAA_0001);
    send(32'hBBBB_0002);
    wr("rc_w1", 4'b0001, 16'h0011, 32'hBBBB_0002);
    send(32'hCCCC_0003);
    wr("rc_w2", 4'b0001, 16'h0012, 32'hCCCC_0003);
    check("rc_end_busy", 64'(busy_out), 64'd0);
    idle();
    check("rc_idle_ena", 64'(mem_ena_out), 64'd0);

    // LDM load wrapping the address
    send(32'h6002_FFFF);
    send(32'h1234_5678);
    wr("ldm_w0", 4'b1000, 16'hFFFF, 32'h1234_5678);
    send(32'h9ABC_DEF0);
    wr("ldm_w1", 4'b1000, 16'h0000, 32'h9ABC_DEF0);
    idle();

    // illegal opcode: payload dropped, flag sticks
    send(32'hE002_0000);
    check("ill_err", 64'(err_out), 64'd1);
    check("ill_busy", 64'(busy_out), 64'd1);
    send(32'h0001_0099);
    check("ill_d0_ena", 64'(mem_ena_out), 64'd0);
    send(32'h0001_0098);
    check("ill_d1_ena", 64'(mem_ena_out), 64'd0);
    check("ill_end_busy", 64'(busy_out), 64'd0);
    send(32'h0001_0020);
    send(32'h0000_0055);
    wr("after_ill", 4'b0001, 16'h0020, 32'h0000_0055);
    check("ill_err_sticky", 64'(err_out), 64'd1);

    // cnt=0 header is consumed without effect
    send(32'h0000_0030);
    check("cnt0_ena", 64'(mem_ena_out), 64'd0);
    check("cnt0_ready", 64'(s_ready_out), 64'd1);
    check("cnt0_busy", 64'(busy_out), 64'd0);
    send(32'h2001_0040);
    send(32'hFEED_BEEF);
    wr("cnt0_pe", 4'b0010, 16'h0040, 32'hFEED_BEEF);
    idle();

    // start with stale-high complete, then a real edge after 10 WAIT cycles
    complete_in = 1'b1;
    send(32'h8000_0000);
    s_valid_in = 1'b0;
    check("st_start", 64'(start_out), 64'd1);
    check("st_ready", 64'(s_ready_out), 64'd0);
    check("st_busy", 64'(busy_out), 64'd1);
    tick();
    check("st_pulse_end", 64'(start_out), 64'd0);
    for (int i = 1; i <= 11; i++) begin
      complete_in = (i <= 7 || i == 11);
      check($sformatf("wait%0d_ready", i), 64'(s_ready_out), 64'd0);
      check($sformatf("wait%0d_done", i), 64'(done_out), 64'd0);
      tick();
    end
    check("run_done", 64'(done_out), 64'd1);
    check("run_cycles", 64'(cycles_out), 64'd11);
    check("run_busy", 64'(busy_out), 64'd0);
    tick();
    check("run_done_end", 64'(done_out), 64'd0);
    complete_in = 1'b0;

    // reset in the middle of a 4-word load
    send(32'h0004_0050);
    send(32'h0000_0011);
    wr("ra_w0", 4'b0001, 16'h0050, 32'h0000_0011);
    s_valid_in = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("ra_ena", 64'(mem_ena_out), 64'd0);
    check("ra_busy", 64'(busy_out), 64'd0);
    check("ra_err", 64'(err_out), 64'd0);
    check("ra_cycles", 64'(cycles_out), 64'd0);
    send(32'h0001_0060);
    check("ra_hdr_ena", 64'(mem_ena_out), 64'd0);
    check("ra_hdr_busy", 64'(busy_out), 64'd1);
    send(32'h0000_0077);
    wr("ra_new", 4'b0001, 16'h0060, 32'h0000_0077);
    idle();
    check("ra_final_ena", 64'(mem_ena_out), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
